// File: rtl/cpu_pkg.sv
// Shared definitions for the Beta-style CPU: PCSEL encodings, default PC vectors,
// fetch FSM state encoding and the branch-offset helper.
package cpu_pkg;

  localparam logic [2:0] PCSEL_INC   = 3'b000;
  localparam logic [2:0] PCSEL_BR    = 3'b001;
  localparam logic [2:0] PCSEL_JMP   = 3'b010;
  localparam logic [2:0] PCSEL_ILLOP = 3'b011;
  localparam logic [2:0] PCSEL_XADR  = 3'b100;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_EXEC  = 2'd2
  } fetch_state_t;

  // Word offset sign-extended into the 31-bit address space below the supervisor bit.
  function automatic logic [30:0] br_offset(input logic [15:0] imm);
    return {{13{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection and PC+4 for the Beta fetch logic.
// Bits 30:0 wrap modulo 2^31; bit 31 (supervisor) follows the PCSEL rules.
module next_pc_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [31:0] jt,
  input  logic [2:0]  pcsel,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic unused_jt;
  assign unused_jt = ^jt[1:0];

  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  always_comb begin
    next_pc = ILLOP_VEC;
    case (pcsel)
      PCSEL_INC:   next_pc = pc_plus4;
      PCSEL_BR:    next_pc = {pc[31], pc_plus4[30:0] + br_offset(imm)};
      // A JMP can drop to user mode but never raise into supervisor mode.
      PCSEL_JMP:   next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
      PCSEL_ILLOP: next_pc = ILLOP_VEC;
      PCSEL_XADR:  next_pc = XADR_VEC;
      default:     next_pc = ILLOP_VEC;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction fetch FSM of the unpipelined Beta CPU.
// Optional FETCH_IRQ_EN adds a level irq input that forces a trap through XADR_VEC.
//
// state    | meaning
// FS_IDLE  | just out of reset, one cycle before the first fetch
// FS_FETCH | imem_req held at pc until imem_ack (or irq trap injected)
// FS_EXEC  | instruction valid downstream; pc advances when not stalled
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic        clk,
  input  logic        RESET_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        exec_stall,
  input  logic [2:0]  PCSEL,
  input  logic [31:0] jt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_IRQ_EN
  ,
  input  logic        irq
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic [31:0]  instr_q, instr_nxt;
  logic         req_q, req_nxt;
  logic         valid_q, valid_nxt;
  logic         irq_q, irq_nxt;
  logic         enter_fetch;
  logic         irq_take;
  logic [31:0]  mux_next_pc;
  logic [31:0]  exec_target;

  next_pc_mux #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_next_pc_mux (
    .pc       (pc_q),
    .imm      (instr_q[15:0]),
    .jt       (jt),
    .pcsel    (PCSEL),
    .pc_plus4 (pc_plus4),
    .next_pc  (mux_next_pc)
  );

  // An injected trap overrides whatever PCSEL the control unit decodes from the ILLOP word.
  assign exec_target = irq_q ? XADR_VEC : mux_next_pc;

`ifdef FETCH_IRQ_EN
  logic [31:0] fetch_pc;
  assign fetch_pc = (state == FS_EXEC) ? exec_target : pc_q;
  assign irq_take = irq & ~fetch_pc[31];
`else
  assign irq_take = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    instr_nxt   = instr_q;
    req_nxt     = req_q;
    valid_nxt   = 1'b0;
    irq_nxt     = irq_q;
    enter_fetch = 1'b0;
    unique case (state)
      FS_IDLE: begin
        state_nxt   = FS_FETCH;
        enter_fetch = 1'b1;
      end
      FS_FETCH: begin
        if (irq_q) begin
          instr_nxt = 32'h0000_0000;
          state_nxt = FS_EXEC;
          valid_nxt = 1'b1;
        end else if (imem_ack) begin
          instr_nxt = imem_rdata;
          req_nxt   = 1'b0;
          state_nxt = FS_EXEC;
          valid_nxt = 1'b1;
        end
      end
      FS_EXEC: begin
        if (exec_stall) begin
          valid_nxt = 1'b1;
        end else begin
          pc_nxt      = exec_target;
          state_nxt   = FS_FETCH;
          enter_fetch = 1'b1;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
    if (enter_fetch) begin
      req_nxt = ~irq_take;
      irq_nxt = irq_take;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= FS_IDLE;
      pc_q    <= RESET_VEC;
      instr_q <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
      req_q   <= req_nxt;
      valid_q <= valid_nxt;
      irq_q   <= irq_nxt;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = {1'b0, pc_q[30:2], 2'b00};
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: next-PC selection, wrap and
// supervisor-bit boundaries, stall, reset abort and (with FETCH_IRQ_EN) irq traps.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        exec_stall = 1'b0;
  logic [2:0]  PCSEL = PCSEL_INC;
  logic [31:0] jt = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_IRQ_EN
  logic        irq = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .exec_stall  (exec_stall),
    .PCSEL       (PCSEL),
    .jt          (jt),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  pcsel;
    logic [31:0] jt;
    int          dly;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_to_exec(input string tag, input logic [31:0] rdata, input int dly,
                               input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " req"}, 32'(imem_req), 32'd1);
    chk({tag, " addr"}, imem_addr, exp_addr);
    repeat (dly) tick();
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, " instr"}, instruction, rdata);
    chk({tag, " valid"}, 32'(instr_valid), 32'd1);
    chk({tag, " req_drop"}, 32'(imem_req), 32'd0);
  endtask

  task automatic exec_step(input string tag, input logic [2:0] sel, input logic [31:0] t_jt,
                           input logic [31:0] exp_pc);
    PCSEL = sel;
    jt    = t_jt;
    tick();
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " valid_end"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    int          vcnt;

    vecs[0]  = '{32'h8000_0000, PCSEL_INC,   32'h0000_0000, 3, 32'h8000_0004};
    vecs[1]  = '{32'h0000_0000, PCSEL_JMP,   32'h0000_0100, 0, 32'h0000_0100};
    vecs[2]  = '{32'h0000_FFFE, PCSEL_BR,    32'h0000_0000, 1, 32'h0000_00FC};
    vecs[3]  = '{32'h0000_0000, PCSEL_JMP,   32'h0000_0100, 0, 32'h0000_0100};
    vecs[4]  = '{32'h0000_0003, PCSEL_BR,    32'h0000_0000, 0, 32'h0000_0110};
    vecs[5]  = '{32'h0000_0000, PCSEL_ILLOP, 32'h0000_0000, 2, 32'h8000_0004};
    vecs[6]  = '{32'h0000_0000, PCSEL_JMP,   32'h8000_0040, 0, 32'h8000_0040};
    vecs[7]  = '{32'h0000_0000, PCSEL_JMP,   32'h0000_1237, 0, 32'h0000_1234};
    vecs[8]  = '{32'h0000_0000, PCSEL_JMP,   32'h0000_0040, 0, 32'h0000_0040};
    vecs[9]  = '{32'h0000_0000, PCSEL_JMP,   32'h8000_1000, 0, 32'h0000_1000};
    vecs[10] = '{32'h0000_0000, 3'b110,      32'h0000_0000, 0, 32'h8000_0004};
    vecs[11] = '{32'h0000_0000, PCSEL_XADR,  32'h0000_0000, 0, 32'h8000_0008};
    vecs[12] = '{32'h0000_0000, 3'b111,      32'h0000_0000, 0, 32'h8000_0004};
    vecs[13] = '{32'h0000_0000, 3'b101,      32'h0000_0000, 0, 32'h8000_0004};
    vecs[14] = '{32'h0000_0000, PCSEL_JMP,   32'h7FFF_FFFC, 0, 32'h7FFF_FFFC};
    vecs[15] = '{32'h0000_0000, PCSEL_INC,   32'h0000_0000, 0, 32'h0000_0000};
    vecs[16] = '{32'h0000_0000, PCSEL_ILLOP, 32'h0000_0000, 0, 32'h8000_0004};
    vecs[17] = '{32'h0000_0000, PCSEL_JMP,   32'hFFFF_FFFC, 0, 32'hFFFF_FFFC};
    vecs[18] = '{32'h0000_0000, PCSEL_INC,   32'h0000_0000, 0, 32'h8000_0000};
    vecs[19] = '{32'h0000_8000, PCSEL_BR,    32'h0000_0000, 0, 32'hFFFE_0004};
    vecs[20] = '{32'h0000_0000, PCSEL_INC,   32'h0000_0000, 0, 32'hFFFE_0008};

    // Reset state
    tick();
    tick();
    chk("rst pc", pc, 32'h8000_0000);
    chk("rst pc_plus4", pc_plus4, 32'h8000_0004);
    chk("rst instr", instruction, 32'h0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst req", 32'(imem_req), 32'd0);
    RESET_N = 1'b1;

    prev = 32'h8000_0000;
    for (int i = 0; i < NV; i++) begin
      fetch_to_exec($sformatf("v%0d", i), vecs[i].rdata, vecs[i].dly, prev & 32'h7FFF_FFFC);
      chk($sformatf("v%0d pc_plus4", i), pc_plus4, {prev[31], prev[30:0] + 31'd4});
      exec_step($sformatf("v%0d", i), vecs[i].pcsel, vecs[i].jt, vecs[i].exp_pc);
      prev = vecs[i].exp_pc;
    end

    // Stall: instr_valid held 5 cycles, pc frozen, ack outside FETCH ignored
    fetch_to_exec("stall", 32'h1111_2222, 0, 32'h7FFE_0008);
    exec_stall = 1'b1;
    PCSEL      = PCSEL_INC;
    vcnt       = instr_valid ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
      end
      tick();
      imem_ack = 1'b0;
      if (instr_valid) vcnt++;
      chk($sformatf("stall%0d pc", k), pc, 32'hFFFE_0008);
    end
    chk("stall instr_kept", instruction, 32'h1111_2222);
    exec_stall = 1'b0;
    tick();
    if (instr_valid) vcnt++;
    chk("stall valid_cycles", 32'(vcnt), 32'd5);
    chk("stall release pc", pc, 32'hFFFE_000C);

    // Reset abandoned mid-FETCH; ack arriving in IDLE must be ignored
    tick();
    chk("midfetch req", 32'(imem_req), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("abort pc", pc, 32'h8000_0000);
    chk("abort instr", instruction, 32'h0);
    chk("abort req", 32'(imem_req), 32'd0);
    tick();
    RESET_N    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("reacq instr", instruction, 32'h0);
    chk("reacq valid", 32'(instr_valid), 32'd0);
    chk("reacq req", 32'(imem_req), 32'd1);
    chk("reacq addr", imem_addr, 32'h0000_0000);
    chk("reacq pc", pc, 32'h8000_0000);
    fetch_to_exec("post", 32'h1234_5678, 1, 32'h0000_0000);
    exec_step("post", PCSEL_INC, 32'h0, 32'h8000_0004);

`ifdef FETCH_IRQ_EN
    // irq taken in user mode: no request, ILLOP word injected, trap to XADR
    fetch_to_exec("irqa", 32'h0000_0000, 0, 32'h0000_0004);
    irq = 1'b1;
    exec_step("irqa", PCSEL_JMP, 32'h0000_0200, 32'h0000_0200);
    chk("irqa no_req", 32'(imem_req), 32'd0);
    chk("irqa pc_plus4", pc_plus4, 32'h0000_0204);
    tick();
    chk("irqa instr", instruction, 32'h0);
    chk("irqa valid", 32'(instr_valid), 32'd1);
    chk("irqa req_exec", 32'(imem_req), 32'd0);
    irq = 1'b0;
    exec_step("irqb", PCSEL_INC, 32'h0, 32'h8000_0008);
    // irq ignored in supervisor mode
    fetch_to_exec("irqc", 32'h0000_5555, 0, 32'h0000_0008);
    irq = 1'b1;
    exec_step("irqc", PCSEL_JMP, 32'h8000_0200, 32'h8000_0200);
    chk("irqc req", 32'(imem_req), 32'd1);
    fetch_to_exec("irqd", 32'h0000_0077, 0, 32'h0000_0200);
    irq = 1'b0;
    exec_step("irqd", PCSEL_INC, 32'h0, 32'h8000_0204);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
